// File: rtl/mem_arbiter.sv
// Shares one SRAM-like bus between the MIPS fetch and data ports: one outstanding
// transaction at a time, data before fetch, results held across pipeline freezes.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              i_stall,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              d_stall,
  input  logic              longest_stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_data_ok
);
  typedef enum logic [2:0] {IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA} arbState;

  arbState           state, stateNext;
  logic              iDone, dDone;
  logic              pendI, pendD;
  logic              iComplete, dComplete;
  logic              latchInst, latchData;
  logic [DATA_W-1:0] instRdataQ, dataRdataQ;
  logic [ADDR_W-1:0] busAddrQ;
  logic [DATA_W-1:0] busWdataQ;
  logic              busWrQ;
  logic [3:0]        busWstrbQ;

  assign pendD     = data_req & ~dDone;
  assign pendI     = inst_req & ~iDone;
  assign iComplete = (state == I_DATA) & bus_data_ok;
  assign dComplete = (state == D_DATA) & bus_data_ok;

  always_comb begin
    stateNext = state;
    latchInst = 1'b0;
    latchData = 1'b0;
    case (state)
      IDLE: begin
        if (pendD) begin
          stateNext = D_ADDR;
          latchData = 1'b1;
        end else if (pendI) begin
          stateNext = I_ADDR;
          latchInst = 1'b1;
        end
      end
      D_ADDR: if (bus_addr_ok) stateNext = D_DATA;
      I_ADDR: if (bus_addr_ok) stateNext = I_DATA;
      D_DATA: begin
        // A waiting fetch follows the data access directly, without an IDLE bubble.
        if (bus_data_ok) begin
          if (pendI) begin
            stateNext = I_ADDR;
            latchInst = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      I_DATA: if (bus_data_ok) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      iDone      <= 1'b0;
      dDone      <= 1'b0;
      instRdataQ <= '0;
      dataRdataQ <= '0;
      busAddrQ   <= '0;
      busWdataQ  <= '0;
      busWrQ     <= 1'b0;
      busWstrbQ  <= 4'b0;
    end else begin
      state <= stateNext;
      // Done flags survive only while the pipeline is frozen, so a finished
      // request is not reissued until the pipeline moves on.
      iDone <= (iDone | iComplete) & longest_stall;
      dDone <= (dDone | dComplete) & longest_stall;
      if (iComplete) instRdataQ <= bus_rdata;
      if (dComplete && !busWrQ) dataRdataQ <= bus_rdata;
      if (latchData) begin
        busAddrQ  <= data_addr;
        busWrQ    <= data_wr;
        busWstrbQ <= data_wr ? data_wstrb : 4'b0;
        busWdataQ <= data_wdata;
      end else if (latchInst) begin
        busAddrQ  <= inst_addr;
        busWrQ    <= 1'b0;
        busWstrbQ <= 4'b0;
        busWdataQ <= '0;
      end
    end
  end

  assign bus_req    = (state == D_ADDR) | (state == I_ADDR);
  assign bus_addr   = busAddrQ;
  assign bus_wdata  = busWdataQ;
  assign bus_wr     = busWrQ;
  assign bus_wstrb  = busWstrbQ;
  assign inst_rdata = iComplete ? bus_rdata : instRdataQ;
  assign data_rdata = dComplete ? bus_rdata : dataRdataQ;
  assign i_stall    = inst_req & ~iDone & ~iComplete;
  assign d_stall    = data_req & ~dDone & ~dComplete;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a slave model pops expected bus transactions from a
// scoreboard queue and checks them; each scenario task checks the port side.
module tb_mem_arbiter;
  logic        clk, rst;
  logic        inst_req, data_req, data_wr, longest_stall, freeze;
  logic [31:0] inst_addr, data_addr, data_wdata, inst_rdata, data_rdata;
  logic [3:0]  data_wstrb, bus_wstrb;
  logic        i_stall, d_stall, bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } busTxn;

  busTxn       expQ[$];
  logic [31:0] rdQ[$];
  int compared = 0;
  int mismatched = 0;
  int addrDelay = 0;
  int dataDelay = 1;

  busTxn cur;
  int    slvCnt;
  bit    slvActive, slvData, slvUnexp;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .i_stall(i_stall),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .d_stall(d_stall),
    .longest_stall(longest_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_rdata(bus_rdata),
    .bus_data_ok(bus_data_ok)
  );

  assign longest_stall = i_stall | d_stall | freeze;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  // Slave model: responds after addrDelay/dataDelay cycles and checks every
  // cycle of a transaction against the scoreboard entry it popped.
  initial begin
    slvActive = 0; slvData = 0; slvUnexp = 0; slvCnt = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    forever begin
      @(posedge clk); #2;
      bus_addr_ok = 0;
      bus_data_ok = 0;
      if (rst) begin
        slvActive = 0; slvData = 0; slvCnt = 0;
      end else begin
        if (!slvActive && bus_req) begin
          slvActive = 1; slvCnt = 0; slvUnexp = 0;
          if (expQ.size() == 0) begin
            compared++; mismatched++; slvUnexp = 1;
            $display("FAIL unexpected_bus_req: got req addr %h want no request", bus_addr);
          end else begin
            cur = expQ.pop_front();
          end
        end
        if (slvActive) begin
          if (!slvUnexp) begin
            compared++;
            if (bus_addr !== cur.addr || bus_wr !== cur.wr || bus_wstrb !== cur.wstrb || bus_wdata !== cur.wdata) begin
              mismatched++;
              $display("FAIL bus_fields: got addr %h wr %b wstrb %b wdata %h want addr %h wr %b wstrb %b wdata %h",
                       bus_addr, bus_wr, bus_wstrb, bus_wdata, cur.addr, cur.wr, cur.wstrb, cur.wdata);
            end
          end
          if (!slvData) begin
            compared++;
            if (bus_req !== 1'b1) begin
              mismatched++;
              $display("FAIL bus_req_hold: got %b want 1", bus_req);
            end
            if (slvCnt == addrDelay) begin
              bus_addr_ok = 1; slvData = 1; slvCnt = 0;
            end else begin
              slvCnt++;
            end
          end else begin
            compared++;
            if (bus_req !== 1'b0) begin
              mismatched++;
              $display("FAIL bus_req_data_phase: got %b want 0", bus_req);
            end
            slvCnt++;
            if (slvCnt == dataDelay) begin
              bus_data_ok = 1;
              bus_rdata = (rdQ.size() != 0) ? rdQ.pop_front() : 32'h0;
              slvActive = 0; slvData = 0; slvCnt = 0;
            end
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1; inst_req = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if (bus_req !== 1'b0 || i_stall !== 1'b1 || d_stall !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got req %b istall %b dstall %b want 0 1 0", bus_req, i_stall, d_stall);
    end
    compared++;
    if (inst_rdata !== 32'h0 || data_rdata !== 32'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 ||
        bus_wr !== 1'b0 || bus_wstrb !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_regs: got irdata %h drdata %h addr %h wdata %h wr %b wstrb %b want all 0",
               inst_rdata, data_rdata, bus_addr, bus_wdata, bus_wr, bus_wstrb);
    end
    @(posedge clk); #1;
    inst_req = 0; rst = 0;
    idle(2);
    $display("txn reset done");
  endtask

  task automatic test_single_fetch;
    int stallCyc = 0;
    bit done = 0;
    addrDelay = 0; dataDelay = 1;
    expQ.push_back('{32'hBFC00000, 1'b0, 4'h0, 32'h0});
    rdQ.push_back(32'h24080001);
    inst_addr = 32'hBFC00000; inst_req = 1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (i_stall) stallCyc++;
      else begin
        done = 1;
        compared++;
        if (inst_rdata !== 32'h24080001) begin
          mismatched++;
          $display("FAIL fetch_bypass: got %h want 24080001", inst_rdata);
        end
      end
      @(posedge clk); #1;
    end
    inst_req = 0;
    compared++;
    if (!done || stallCyc !== 2) begin
      mismatched++;
      $display("FAIL fetch_stall_len: got %0d done %0d want 2 done 1", stallCyc, done);
    end
    idle(3);
    @(negedge clk);
    compared++;
    if (inst_rdata !== 32'h24080001) begin
      mismatched++;
      $display("FAIL fetch_hold: got %h want 24080001", inst_rdata);
    end
    @(posedge clk); #1;
    $display("txn fetch addr bfc00000 rdata %h stall %0d", inst_rdata, stallCyc);
  endtask

  task automatic test_contention;
    int iCyc = 0, dCyc = 0;
    bit done = 0, dSeen = 0;
    expQ.push_back('{32'h80000010, 1'b0, 4'h0, 32'h0});
    expQ.push_back('{32'hBFC00004, 1'b0, 4'h0, 32'h0});
    rdQ.push_back(32'h11111111);
    rdQ.push_back(32'h22222222);
    inst_addr = 32'hBFC00004; data_addr = 32'h80000010; data_wr = 0; data_wstrb = 4'h0; data_wdata = 32'h0;
    inst_req = 1; data_req = 1;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (i_stall) iCyc++;
      if (d_stall) dCyc++;
      if (c == 1) begin
        compared++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h80000010 || bus_wr !== 1'b0) begin
          mismatched++;
          $display("FAIL contention_first: got req %b addr %h wr %b want 1 80000010 0", bus_req, bus_addr, bus_wr);
        end
      end
      if (c == 3) begin
        compared++;
        if (bus_req !== 1'b1 || bus_addr !== 32'hBFC00004) begin
          mismatched++;
          $display("FAIL contention_fetch_req: got req %b addr %h want 1 bfc00004", bus_req, bus_addr);
        end
      end
      if (!d_stall && !dSeen) begin
        dSeen = 1;
        compared++;
        if (data_rdata !== 32'h11111111) begin
          mismatched++;
          $display("FAIL contention_load: got %h want 11111111", data_rdata);
        end
      end
      if (!i_stall && !d_stall) begin
        done = 1;
        compared++;
        if (inst_rdata !== 32'h22222222) begin
          mismatched++;
          $display("FAIL contention_fetch: got %h want 22222222", inst_rdata);
        end
      end
      @(posedge clk); #1;
    end
    inst_req = 0; data_req = 0;
    compared++;
    if (!done || dCyc !== 2 || iCyc - dCyc !== 2) begin
      mismatched++;
      $display("FAIL contention_stalls: got d %0d i %0d want d 2 i 4", dCyc, iCyc);
    end
    idle(2);
    @(negedge clk);
    compared++;
    if (data_rdata !== 32'h11111111 || inst_rdata !== 32'h22222222) begin
      mismatched++;
      $display("FAIL contention_hold: got %h %h want 11111111 22222222", data_rdata, inst_rdata);
    end
    @(posedge clk); #1;
    $display("txn contention dstall %0d istall %0d", dCyc, iCyc);
  endtask

  task automatic test_store;
    int dCyc = 0;
    bit done = 0;
    expQ.push_back('{32'h80000004, 1'b1, 4'b0011, 32'hDEADBEEF});
    rdQ.push_back(32'hFFFF0000);
    data_addr = 32'h80000004; data_wr = 1; data_wstrb = 4'b0011; data_wdata = 32'hDEADBEEF;
    data_req = 1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (d_stall) dCyc++; else done = 1;
      @(posedge clk); #1;
    end
    data_req = 0; data_wr = 0; data_wstrb = 4'h0;
    compared++;
    if (!done || dCyc !== 2) begin
      mismatched++;
      $display("FAIL store_stall: got %0d done %0d want 2 done 1", dCyc, done);
    end
    @(negedge clk);
    compared++;
    if (data_rdata !== 32'h11111111) begin
      mismatched++;
      $display("FAIL store_rdata_kept: got %h want 11111111", data_rdata);
    end
    @(posedge clk); #1;
    idle(1);
    $display("txn store addr 80000004 wdata deadbeef stall %0d", dCyc);
  endtask

  task automatic test_freeze;
    expQ.push_back('{32'hBFC00008, 1'b0, 4'h0, 32'h0});
    rdQ.push_back(32'hAAAA5555);
    freeze = 1;
    inst_addr = 32'hBFC00008; inst_req = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      compared++;
      if (c < 2) begin
        if (i_stall !== 1'b1) begin
          mismatched++;
          $display("FAIL freeze_pre c%0d: got istall %b want 1", c, i_stall);
        end
      end else if (c <= 8) begin
        if (i_stall !== 1'b0 || inst_rdata !== 32'hAAAA5555) begin
          mismatched++;
          $display("FAIL freeze_hold c%0d: got istall %b rdata %h want 0 aaaa5555", c, i_stall, inst_rdata);
        end
      end else begin
        if (i_stall !== 1'b1) begin
          mismatched++;
          $display("FAIL freeze_done_clear: got istall %b want 1", i_stall);
        end
        #1 inst_req = 0;
      end
      @(posedge clk); #1;
      if (c == 7) freeze = 0;
    end
    idle(3);
    $display("txn freeze fetch rdata %h", inst_rdata);
  endtask

  task automatic test_wait_states;
    int dCyc = 0;
    bit done = 0;
    addrDelay = 3; dataDelay = 5;
    expQ.push_back('{32'h80000020, 1'b0, 4'h0, 32'h0});
    rdQ.push_back(32'h5A5A0F0F);
    data_addr = 32'h80000020; data_wr = 0; data_wstrb = 4'h0; data_wdata = 32'h0;
    data_req = 1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (d_stall) dCyc++;
      else begin
        done = 1;
        compared++;
        if (data_rdata !== 32'h5A5A0F0F) begin
          mismatched++;
          $display("FAIL wait_rdata: got %h want 5a5a0f0f", data_rdata);
        end
      end
      @(posedge clk); #1;
    end
    data_req = 0;
    compared++;
    if (!done || dCyc !== 9) begin
      mismatched++;
      $display("FAIL wait_stall_len: got %0d done %0d want 9 done 1", dCyc, done);
    end
    addrDelay = 0; dataDelay = 1;
    idle(2);
    $display("txn wait_states load 80000020 stall %0d", dCyc);
  endtask

  task automatic test_reset_mid;
    addrDelay = 0; dataDelay = 4;
    expQ.push_back('{32'h80000030, 1'b0, 4'h0, 32'h0});
    rdQ.push_back(32'h33333333);
    data_addr = 32'h80000030; data_wr = 0; data_req = 1;
    idle(3);
    rst = 1; data_req = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    compared++;
    if (bus_req !== 1'b0 || data_rdata !== 32'h0 || inst_rdata !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_mid_out: got req %b drdata %h irdata %h want 0 0 0", bus_req, data_rdata, inst_rdata);
    end
    compared++;
    if (bus_addr !== 32'h0 || bus_wr !== 1'b0 || bus_wstrb !== 4'h0 || bus_wdata !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_mid_bus: got addr %h wr %b wstrb %b wdata %h want all 0", bus_addr, bus_wr, bus_wstrb, bus_wdata);
    end
    @(posedge clk); #1;
    idle(3);
    rdQ.delete();
    addrDelay = 0; dataDelay = 1;
    $display("txn reset_mid abort load 80000030");
  endtask

  initial begin
    rst = 1; inst_req = 0; data_req = 0; data_wr = 0; data_wstrb = 0; freeze = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_store();
    test_freeze();
    test_wait_states();
    test_reset_mid();
    compared++;
    if (expQ.size() !== 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
